// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: widths, OPMODE bit positions and X/Z mux encodings shared by the dsp48a1 slice.
`timescale 1ns/1ps
package dsp48a1_pkg;
    localparam int A_W = 18;
    localparam int M_W = 36;
    localparam int P_W = 48;
    localparam int OP_X        = 0;
    localparam int OP_Z        = 2;
    localparam int OP_PRE_SEL  = 4;
    localparam int OP_CIN      = 5;
    localparam int OP_PRE_SUB  = 6;
    localparam int OP_POST_SUB = 7;
    typedef enum logic [1:0] {X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_DAB = 2'd3} x_sel_e;
    typedef enum logic [1:0] {Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3} z_sel_e;
endpackage

// File: rtl/dsp48a1_reg_mux.sv
// dsp48a1_reg_mux: optional pipeline register with clock enable and async active-low clear, or a plain wire.
`timescale 1ns/1ps
module dsp48a1_reg_mux #(
    parameter int W  = 18,
    parameter int EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (EN != 0) begin : g_reg
        logic [W-1:0] r;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r <= '0;
            else if (ce) r <= d;
        assign q = r;
    end else begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, ce};
        assign q = d;
    end
endmodule

// File: rtl/dsp48a1.sv
// dsp48a1: DSP48A1-style slice: pre-adder, 18x18 unsigned multiplier, 48-bit post-adder/accumulator.
// Define DSP48A1_PREADDER_EN to build the D+/-B pre-adder; otherwise B1 always takes B0.
`timescale 1ns/1ps
module dsp48a1
    import dsp48a1_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT_SEL = "DIRECT"
) (
    input  logic           CLK,
    input  logic           RSTA,
    input  logic           RSTB,
    input  logic           RSTC,
    input  logic           RSTD,
    input  logic           RSTM,
    input  logic           RSTP,
    input  logic           RSTOPMODE,
    input  logic           RSTCARRYIN,
    input  logic           RSTCARRYOUT,
    input  logic           CEA,
    input  logic           CEB,
    input  logic           CEC,
    input  logic           CED,
    input  logic           CEM,
    input  logic           CEP,
    input  logic           CEOPMODE,
    input  logic           CECARRYIN,
    input  logic           CECARRYOUT,
    input  logic [A_W-1:0] A,
    input  logic [A_W-1:0] B,
    input  logic [A_W-1:0] D,
    input  logic [A_W-1:0] BCIN,
    input  logic [P_W-1:0] C,
    input  logic [P_W-1:0] PCIN,
    input  logic [7:0]     OPMODE,
    input  logic           CARRYIN,
    output logic [M_W-1:0] M,
    output logic [P_W-1:0] P,
    output logic [P_W-1:0] PCOUT,
    output logic [A_W-1:0] BCOUT,
    output logic           CARRYOUT,
    output logic           CARRYOUTF
);
    logic [A_W-1:0] a0, b0, d_r, a1, b1, b1_d;
    logic [P_W-1:0] c_r, x_mux, z_mux;
    logic [7:0]     op;
    logic           cyi;
    logic [P_W:0]   post;

    dsp48a1_reg_mux #(.W(A_W), .EN(A0REG)) u_a0 (.clk(CLK), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0));
    dsp48a1_reg_mux #(.W(A_W), .EN(B0REG)) u_b0 (.clk(CLK), .rst_n(RSTB), .ce(CEB),
        .d(B_INPUT_SEL == "CASCADE" ? BCIN : B), .q(b0));
    dsp48a1_reg_mux #(.W(P_W), .EN(CREG)) u_c (.clk(CLK), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_r));
    dsp48a1_reg_mux #(.W(A_W), .EN(DREG)) u_d (.clk(CLK), .rst_n(RSTD), .ce(CED), .d(D), .q(d_r));
    dsp48a1_reg_mux #(.W(8), .EN(OPMODEREG)) u_op (.clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE),
        .d(OPMODE), .q(op));

`ifdef DSP48A1_PREADDER_EN
    logic [A_W-1:0] pre;
    assign pre  = op[OP_PRE_SUB] ? d_r - b0 : d_r + b0;
    assign b1_d = op[OP_PRE_SEL] ? pre : b0;
`else
    logic unused_pre;
    assign unused_pre = ^{d_r[A_W-1:12], op[OP_PRE_SUB], op[OP_PRE_SEL]};
    assign b1_d = b0;
`endif

    dsp48a1_reg_mux #(.W(A_W), .EN(A1REG)) u_a1 (.clk(CLK), .rst_n(RSTA), .ce(CEA), .d(a0), .q(a1));
    dsp48a1_reg_mux #(.W(A_W), .EN(B1REG)) u_b1 (.clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b1_d), .q(b1));
    dsp48a1_reg_mux #(.W(M_W), .EN(MREG)) u_m (.clk(CLK), .rst_n(RSTM), .ce(CEM), .d(a1 * b1), .q(M));
    // Carry-in is staged alongside M so it lines up with the product at the post-adder
    dsp48a1_reg_mux #(.W(1), .EN(CARRYINREG)) u_cyi (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN),
        .d(CARRYINSEL == "CARRYIN" ? CARRYIN : op[OP_CIN]), .q(cyi));

    always_comb begin
        x_mux = op[OP_X +: 2] == X_ZERO ? '0 :
                op[OP_X +: 2] == X_M    ? {{(P_W-M_W){1'b0}}, M} :
                op[OP_X +: 2] == X_P    ? P : {d_r[11:0], a1, b1};
        z_mux = op[OP_Z +: 2] == Z_ZERO ? '0 :
                op[OP_Z +: 2] == Z_PCIN ? PCIN :
                op[OP_Z +: 2] == Z_P    ? P : c_r;
        post  = op[OP_POST_SUB] ? {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cyi})
                                : {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cyi};
    end

    dsp48a1_reg_mux #(.W(P_W), .EN(PREG)) u_p (.clk(CLK), .rst_n(RSTP), .ce(CEP), .d(post[P_W-1:0]), .q(P));
    dsp48a1_reg_mux #(.W(1), .EN(CARRYOUTREG)) u_co (.clk(CLK), .rst_n(RSTCARRYOUT), .ce(CECARRYOUT),
        .d(post[P_W]), .q(CARRYOUT));

    assign BCOUT     = b1;
    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;
endmodule

// File: tb/tb_dsp48a1.sv
// tb_dsp48a1: directed self-checking bench for dsp48a1 in the all-registers configuration.
`timescale 1ns/1ps
module tb_dsp48a1;
    logic        clk = 1'b0;
    logic        rst_all, rstp, cep;
    logic [17:0] a, b, d, bcin;
    logic [47:0] c, pcin;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] p, pcout;
    logic [17:0] bcout;
    logic        co, cof;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dsp48a1 #(.A0REG(1), .B0REG(1)) dut (
        .CLK(clk),
        .RSTA(rst_all), .RSTB(rst_all), .RSTC(rst_all), .RSTD(rst_all), .RSTM(rst_all),
        .RSTP(rst_all & rstp), .RSTOPMODE(rst_all), .RSTCARRYIN(rst_all), .RSTCARRYOUT(rst_all),
        .CEA(1'b1), .CEB(1'b1), .CEC(1'b1), .CED(1'b1), .CEM(1'b1), .CEP(cep),
        .CEOPMODE(1'b1), .CECARRYIN(1'b1), .CECARRYOUT(1'b1),
        .A(a), .B(b), .D(d), .BCIN(bcin), .C(c), .PCIN(pcin), .OPMODE(opmode), .CARRYIN(1'b0),
        .M(m), .P(p), .PCOUT(pcout), .BCOUT(bcout), .CARRYOUT(co), .CARRYOUTF(cof)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef DSP48A1_PREADDER_EN
        automatic logic [47:0] pa_m = 48'd200, pa_p = 48'd211, pa_b = 48'd20;
        automatic logic [47:0] sb_m = 48'd100, sb_p = 48'd400;
`else
        automatic logic [47:0] pa_m = 48'd100, pa_p = 48'd111, pa_b = 48'd10;
        automatic logic [47:0] sb_m = 48'd50,  sb_p = 48'd450;
`endif
        rst_all = 1'b0; rstp = 1'b1; cep = 1'b1;
        a = 18'd10; b = 18'd10; d = 18'd10; c = 48'd10; bcin = 18'h3FFFF; pcin = 48'd0;
        opmode = 8'h3D;
        tick(2);
        check("held_reset_m", 48'(m), 48'd0);
        check("held_reset_p", p, 48'd0);
        // Pre-add multiply and pipeline latency
        rst_all = 1'b1;
        tick(3);
        check("preadd_m_3edges", 48'(m), pa_m);
        check("preadd_p_3edges", p, 48'd11);
        tick(1);
        check("preadd_p", p, pa_p);
        check("preadd_pcout", pcout, pa_p);
        check("preadd_co", 48'(co), 48'd0);
        check("preadd_bcout", 48'(bcout), pa_b);
        // Asynchronous clear, sampled before any clock edge
        rst_all = 1'b0;
        #2;
        check("rst_m", 48'(m), 48'd0);
        check("rst_p", p, 48'd0);
        check("rst_pcout", pcout, 48'd0);
        check("rst_bcout", 48'(bcout), 48'd0);
        check("rst_co", 48'(co), 48'd0);
        check("rst_cof", 48'(cof), 48'd0);
        // Pre-subtract and post-subtract
        rst_all = 1'b1;
        a = 18'd5; d = 18'd30; b = 18'd10; c = 48'd500; opmode = 8'hDD;
        tick(6);
        check("sub_m", 48'(m), sb_m);
        check("sub_p", p, sb_p);
        check("sub_co", 48'(co), 48'd0);
        // Post-subtract underflow sets the borrow
        a = 18'd1; b = 18'd1; c = 48'd0; opmode = 8'h8D;
        tick(6);
        check("borrow_m", 48'(m), 48'd1);
        check("borrow_p", p, 48'hFFFF_FFFF_FFFF);
        check("borrow_co", 48'(co), 48'd1);
        // Add overflow sets the carry
        c = 48'hFFFF_FFFF_FFFF; opmode = 8'h0D;
        tick(6);
        check("carry_p", p, 48'd0);
        check("carry_co", 48'(co), 48'd1);
        check("carry_cof", 48'(cof), 48'd1);
        // X = {D[11:0], A1, B1}, Z = PCIN
        a = 18'd2; b = 18'd3; d = 18'd1; pcin = 48'd5; opmode = 8'h07;
        tick(6);
        check("dab_p", p, 48'h0010_0008_0008);
        check("dab_co", 48'(co), 48'd0);
        check("dab_bcout", 48'(bcout), 48'd3);
        // Accumulate from a cleared P
        opmode = 8'h09;
        tick(6);
        rstp = 1'b0;
        #2;
        check("acc_rstp", p, 48'd0);
        rstp = 1'b1;
        tick(1);
        check("acc_1", p, 48'd6);
        tick(1);
        check("acc_2", p, 48'd12);
        tick(1);
        check("acc_3", p, 48'd18);
        cep = 1'b0;
        tick(2);
        check("cep_hold_p", p, 48'd18);
        check("cep_hold_pcout", pcout, 48'd18);
        cep = 1'b1;
        tick(1);
        check("cep_resume", p, 48'd24);
        tick(1);
        check("cep_resume2", pcout, 48'd30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
